// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Conditions one raw, asynchronous, active-low push-button pin.
//                The pin is brought into the clk domain through a 2-FF
//                synchroniser. The synchronised level is then accepted only
//                after it has differed from the current debounced level for
//                STABLE_CYCLES+1 consecutive cycles. Outputs:
//                  db_button_out : clean level, active-low (0 = pressed)
//                  press_pulse   : one-cycle high on an accepted 1->0
//                  release_pulse : one-cycle high on an accepted 0->1
//                  bounce_count  : saturating count of aborted checks
//                Ports:
//                  clk, rst (synchronous, active-high), button_raw_in,
//                  db_button_out, press_pulse, release_pulse,
//                  bounce_count[BOUNCE_W-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_WIDTH     = 20,
    parameter int BOUNCE_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button_raw_in,
    output logic                db_button_out,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic [BOUNCE_W-1:0] bounce_count
);

    localparam logic [0:0] S_STABLE = 1'b0;
    localparam logic [0:0] S_CHECK  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] c_stable     = CNT_WIDTH'(STABLE_CYCLES);
    localparam logic [BOUNCE_W-1:0]  c_bounce_max = {BOUNCE_W{1'b1}};

    logic                 r_sync_q1;
    logic                 r_sync_q2;
    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_db;
    logic                 r_press;
    logic                 r_release;
    logic [BOUNCE_W-1:0]  r_bounce;

    logic [0:0]           w_state_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_db_nxt;
    logic                 w_press_nxt;
    logic                 w_release_nxt;
    logic [BOUNCE_W-1:0]  w_bounce_nxt;

    // State register, synchroniser and registered outputs. The synchroniser
    // resets to 1 (released) so a reset never fabricates a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q1 <= 1'b1;
            r_sync_q2 <= 1'b1;
            r_state   <= S_STABLE;
            r_cnt     <= '0;
            r_db      <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_bounce  <= '0;
        end else begin
            r_sync_q1 <= button_raw_in;
            r_sync_q2 <= r_sync_q1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_db      <= w_db_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_bounce  <= w_bounce_nxt;
        end
    end

    // Next-state logic. The counter holds the number of consecutive cycles
    // the mismatch has been seen so far; acceptance happens on the cycle
    // the mismatch is seen once more with the counter at STABLE_CYCLES.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_db_nxt      = r_db;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_bounce_nxt  = r_bounce;

        case (r_state)
            S_STABLE: begin
                if (r_sync_q2 != r_db) begin
                    w_state_nxt = S_CHECK;
                    w_cnt_nxt   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            S_CHECK: begin
                if (r_sync_q2 == r_db) begin
                    // Input fell back before it was accepted: one bounce.
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                    if (r_bounce != c_bounce_max) begin
                        w_bounce_nxt = r_bounce + 1'b1;
                    end
                end else if (r_cnt == c_stable) begin
                    w_db_nxt      = r_sync_q2;
                    w_press_nxt   = ~r_sync_q2;
                    w_release_nxt = r_sync_q2;
                    w_state_nxt   = S_STABLE;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign db_button_out = r_db;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign bounce_count  = r_bounce;

endmodule
`default_nettype wire
